// File: rtl/ysyx_lsu_axi_bridge.sv
// Single-outstanding LSU-to-AXI4-Lite master bridge: one load or store at a time,
// store data/strobes lane-shifted by address offset, with a per-transaction watchdog.
module ysyx_lsu_axi_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // LSU load
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  // LSU store
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              lsu_err,
  // AXI4-Lite master
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] AR   = 3'd1;
  localparam logic [2:0] R    = 3'd2;
  localparam logic [2:0] W    = 3'd3;
  localparam logic [2:0] B    = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_done, w_done;

  logic [DATA_W-1:0] wdata_sh;
  logic [3:0]        wstrb_sh;
  logic              tmo, aw_ok, w_ok;

  // Load strobe and the upper store strobe bits carry no information for a raw-word bus.
  logic unused_ok;
  assign unused_ok = ^{lsu_rstrb, lsu_wstrb[7:4]};

  assign wdata_sh = lsu_wdata << {lsu_awaddr[1:0], 3'b000};
  assign wstrb_sh = lsu_wstrb[3:0] << lsu_awaddr[1:0];
  assign tmo      = (cnt == CNT_W'(TIMEOUT - 1));
  assign aw_ok    = aw_done | (awvalid & awready);
  assign w_ok     = w_done  | (wvalid  & wready);

  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign arvalid = (state == AR);
  assign rready  = (state == R);
  assign awvalid = (state == W) & ~aw_done;
  assign wvalid  = (state == W) & ~w_done;
  assign bready  = (state == B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      lsu_rdata  <= '0;
      lsu_rvalid <= 1'b0;
      lsu_wready <= 1'b0;
      lsu_err    <= 1'b0;
    end else begin
      lsu_rvalid <= 1'b0;
      lsu_wready <= 1'b0;
      lsu_err    <= 1'b0;
      if (state inside {AR, R, W, B}) cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (lsu_arvalid) begin
            addr_q <= lsu_araddr;
            state  <= AR;
          end else if (lsu_awvalid && lsu_wvalid) begin
            addr_q  <= lsu_awaddr;
            wdata_q <= wdata_sh;
            wstrb_q <= wstrb_sh;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= W;
          end
        end
        AR: begin
          if (arready) state <= R;
          else if (tmo) begin
            lsu_rvalid <= 1'b1;
            lsu_err    <= 1'b1;
            lsu_rdata  <= '0;
            state      <= DONE;
          end
        end
        R: begin
          // A response landing on the last allowed cycle still counts as real.
          if (rvalid) begin
            lsu_rdata  <= rdata;
            lsu_rvalid <= 1'b1;
            lsu_err    <= (rresp != 2'b00);
            state      <= DONE;
          end else if (tmo) begin
            lsu_rvalid <= 1'b1;
            lsu_err    <= 1'b1;
            lsu_rdata  <= '0;
            state      <= DONE;
          end
        end
        W: begin
          if (aw_ok && w_ok) state <= B;
          else if (tmo) begin
            lsu_wready <= 1'b1;
            lsu_err    <= 1'b1;
            state      <= DONE;
          end else begin
            aw_done <= aw_ok;
            w_done  <= w_ok;
          end
        end
        B: begin
          if (bvalid) begin
            lsu_wready <= 1'b1;
            lsu_err    <= (bresp != 2'b00);
            state      <= DONE;
          end else if (tmo) begin
            lsu_wready <= 1'b1;
            lsu_err    <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;  // DONE: one dead cycle so a held request is not reissued
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_axi_bridge.sv
// Bench for ysyx_lsu_axi_bridge: AXI slave with programmable latencies plus a
// transaction-level expectation model (lane placement, response, error, timeout).
module tb_ysyx_lsu_axi_bridge;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lsu_araddr, lsu_awaddr, lsu_wdata, lsu_rdata;
  logic        lsu_arvalid, lsu_awvalid, lsu_wvalid, lsu_rvalid, lsu_wready, lsu_err;
  logic [7:0]  lsu_rstrb, lsu_wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int n_vec = 0;
  int n_err = 0;

  ysyx_lsu_axi_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_err(lsu_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Observations of the last transaction
  int          g_ar_hs, g_r_hs, g_aw_hs, g_w_hs, g_b_hs, g_rv_n, g_wr_n, g_arv_cyc;
  int          g_rv_cyc, g_aw_first;
  bit          g_bound;
  logic [31:0] g_araddr, g_awaddr, g_wdata, g_rdata;
  logic [3:0]  g_wstrb;
  logic        g_rerr, g_werr;

  // Expected bus image of a store, built byte lane by byte lane
  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] off);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off)) r[8*i +: 8] = d[8*(i-int'(off)) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [7:0] s, input logic [1:0] off);
    logic [3:0] r = 4'h0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off)) r[i] = s[i-int'(off)];
    return r;
  endfunction

  task automatic slave_idle();
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = 32'h0; rresp = 2'b00; bresp = 2'b00;
  endtask

  // Runs one load and/or store request against a latency-programmable slave.
  // Called at posedge+1; returns at posedge+1 with the bridge idle.
  task automatic run_txn(input bit ld, input logic [31:0] laddr, input bit st,
                         input logic [31:0] saddr, input logic [31:0] sdata, input logic [7:0] sstrb,
                         input int ar_lat, input int r_lat, input int aw_lat, input int w_lat,
                         input int b_lat, input logic [31:0] rdat, input logic [1:0] rrsp,
                         input logic [1:0] brsp);
    int arc = 0, rc = 0, awc = 0, wc = 0, bc = 0, tail = 0;
    g_ar_hs = 0; g_r_hs = 0; g_aw_hs = 0; g_w_hs = 0; g_b_hs = 0; g_rv_n = 0; g_wr_n = 0;
    g_arv_cyc = 0; g_rv_cyc = -1; g_aw_first = -1; g_bound = 0;
    g_araddr = 'x; g_awaddr = 'x; g_wdata = 'x; g_wstrb = 'x; g_rerr = 0; g_werr = 0;
    lsu_araddr = laddr; lsu_arvalid = ld; lsu_rstrb = 8'($urandom_range(0, 255));
    lsu_awaddr = saddr; lsu_wdata = sdata; lsu_wstrb = sstrb;
    lsu_awvalid = st; lsu_wvalid = st;
    for (int cyc = 1; ; cyc++) begin
      @(posedge clk); #1;
      if (lsu_rvalid) begin
        g_rv_n++; g_rdata = lsu_rdata; g_rerr = lsu_err; g_rv_cyc = cyc; lsu_arvalid = 0;
      end
      if (lsu_wready) begin
        g_wr_n++; g_werr = lsu_err; lsu_awvalid = 0; lsu_wvalid = 0;
      end
      if ((!ld || g_rv_n > 0) && (!st || g_wr_n > 0)) tail++;
      if (tail == 4 || cyc > 300) begin
        g_bound = (tail != 4);
        break;
      end
      arready = arvalid && (arc >= ar_lat);
      if (arvalid) begin arc++; g_arv_cyc++; end
      if (arvalid && arready) begin g_ar_hs++; g_araddr = araddr; end
      rvalid = rready && (rc >= r_lat); rdata = rdat; rresp = rrsp;
      if (rready) rc++;
      if (rvalid && rready) g_r_hs++;
      if (awvalid && g_aw_first < 0) g_aw_first = cyc;
      awready = awvalid && (awc >= aw_lat);
      if (awvalid) awc++;
      if (awvalid && awready) begin g_aw_hs++; g_awaddr = awaddr; end
      wready = wvalid && (wc >= w_lat);
      if (wvalid) wc++;
      if (wvalid && wready) begin g_w_hs++; g_wdata = wdata; g_wstrb = wstrb; end
      bvalid = bready && (bc >= b_lat); bresp = brsp;
      if (bready) bc++;
      if (bvalid && bready) g_b_hs++;
    end
    slave_idle();
    lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin n_err++;
      $display("FAIL reset_axi_valid got=%b want=00000", {arvalid, rready, awvalid, wvalid, bready}); end
    n_vec++; if ({lsu_rvalid, lsu_wready, lsu_err} !== 3'b0) begin n_err++;
      $display("FAIL reset_lsu_pulse got=%b want=000", {lsu_rvalid, lsu_wready, lsu_err}); end
    n_vec++; if (lsu_rdata !== 32'h0) begin n_err++;
      $display("FAIL reset_rdata got=%h want=00000000", lsu_rdata); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic check_load(input string nm, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] rsp);
    n_vec++; if (g_bound) begin n_err++; $display("FAIL %s no_completion_within_bound", nm); end
    n_vec++; if (g_ar_hs !== 1 || g_araddr !== a) begin n_err++;
      $display("FAIL %s araddr hs=%0d got=%h want=%h", nm, g_ar_hs, g_araddr, a); end
    n_vec++; if (g_rv_n !== 1 || g_wr_n !== 0) begin n_err++;
      $display("FAIL %s pulses rvalid=%0d wready=%0d want 1/0", nm, g_rv_n, g_wr_n); end
    n_vec++; if (g_rdata !== d) begin n_err++;
      $display("FAIL %s rdata got=%h want=%h", nm, g_rdata, d); end
    n_vec++; if (g_rerr !== (rsp != 2'b00)) begin n_err++;
      $display("FAIL %s err got=%b want=%b", nm, g_rerr, rsp != 2'b00); end
  endtask

  task automatic check_store(input string nm, input logic [31:0] a, input logic [31:0] d,
                             input logic [7:0] s, input logic [1:0] rsp, input logic [31:0] hold);
    n_vec++; if (g_bound) begin n_err++; $display("FAIL %s no_completion_within_bound", nm); end
    n_vec++; if (g_aw_hs !== 1 || g_w_hs !== 1 || g_b_hs !== 1) begin n_err++;
      $display("FAIL %s handshakes aw=%0d w=%0d b=%0d want 1/1/1", nm, g_aw_hs, g_w_hs, g_b_hs); end
    n_vec++; if (g_awaddr !== a) begin n_err++;
      $display("FAIL %s awaddr got=%h want=%h", nm, g_awaddr, a); end
    n_vec++; if (g_wstrb !== exp_wstrb(s, a[1:0]) || g_wdata !== exp_wdata(d, a[1:0])) begin n_err++;
      $display("FAIL %s wstrb/wdata got=%h/%h want=%h/%h", nm, g_wstrb, g_wdata,
               exp_wstrb(s, a[1:0]), exp_wdata(d, a[1:0])); end
    n_vec++; if (g_wr_n !== 1 || g_rv_n !== 0 || g_werr !== (rsp != 2'b00)) begin n_err++;
      $display("FAIL %s pulses wready=%0d rvalid=%0d err=%b want 1/0/%b", nm, g_wr_n, g_rv_n,
               g_werr, rsp != 2'b00); end
    n_vec++; if (lsu_rdata !== hold) begin n_err++;
      $display("FAIL %s rdata_hold got=%h want=%h", nm, lsu_rdata, hold); end
  endtask

  task automatic test_load();
    logic [31:0] a, d;
    logic [1:0]  rsp;
    run_txn(1, 32'h8000_0004, 0, 0, 0, 0, 2, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b00);
    check_load("load_directed", 32'h8000_0004, 32'hDEAD_BEEF, 2'b00);
    for (int i = 0; i < 8; i++) begin
      a = $urandom; d = $urandom; rsp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      run_txn(1, a, 0, 0, 0, 0, $urandom_range(0, 4), $urandom_range(0, 4), 0, 0, 0, d, rsp, 2'b00);
      check_load("load_random", a, d, rsp);
    end
  endtask

  task automatic test_store();
    logic [31:0] a, d;
    logic [7:0]  s;
    logic [1:0]  rsp;
    run_txn(0, 0, 1, 32'h8000_0003, 32'h0000_00AB, 8'h01, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00);
    check_store("sb_directed", 32'h8000_0003, 32'h0000_00AB, 8'h01, 2'b00, lsu_rdata);
    n_vec++; if (g_wstrb !== 4'h8 || g_wdata !== 32'hAB00_0000) begin n_err++;
      $display("FAIL sb_lane got=%h/%h want=8/ab000000", g_wstrb, g_wdata); end
    run_txn(0, 0, 1, 32'h8000_0002, 32'h0000_1234, 8'h03, 0, 0, 3, 0, 2, 0, 2'b00, 2'b00);
    check_store("sh_wready_first", 32'h8000_0002, 32'h0000_1234, 8'h03, 2'b00, lsu_rdata);
    n_vec++; if (g_wstrb !== 4'hC) begin n_err++;
      $display("FAIL sh_wstrb got=%h want=c", g_wstrb); end
    for (int i = 0; i < 8; i++) begin
      a = $urandom; d = $urandom;
      case ($urandom_range(0, 2)) 0: s = 8'h01; 1: s = 8'h03; default: s = 8'h0f; endcase
      rsp = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      run_txn(0, 0, 1, a, d, s, 0, 0, $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), 0, 2'b00, rsp);
      check_store("store_random", a, d, s, rsp, lsu_rdata);
    end
  endtask

  task automatic test_simultaneous();
    run_txn(1, 32'h8000_0100, 1, 32'h8000_0201, 32'h0000_55AA, 8'h03, 1, 1, 1, 1, 1,
            32'h0BAD_F00D, 2'b00, 2'b00);
    n_vec++; if (g_bound || g_rv_n !== 1 || g_wr_n !== 1 || g_ar_hs !== 1 || g_b_hs !== 1) begin n_err++;
      $display("FAIL simul_both_done rv=%0d wr=%0d ar=%0d b=%0d want 1/1/1/1", g_rv_n, g_wr_n, g_ar_hs, g_b_hs); end
    n_vec++; if (g_aw_first <= g_rv_cyc) begin n_err++;
      $display("FAIL simul_order aw_first_cycle=%0d must follow load_done_cycle=%0d", g_aw_first, g_rv_cyc); end
    n_vec++; if (g_araddr !== 32'h8000_0100 || g_awaddr !== 32'h8000_0201 ||
                 g_wdata !== exp_wdata(32'h0000_55AA, 2'd1)) begin n_err++;
      $display("FAIL simul_payload got=%h/%h/%h", g_araddr, g_awaddr, g_wdata); end
  endtask

  task automatic test_timeout();
    run_txn(1, 32'h8000_0040, 0, 0, 0, 0, 100000, 0, 0, 0, 0, 32'h1111_1111, 2'b00, 2'b00);
    n_vec++; if (g_bound || g_rv_n !== 1 || g_rerr !== 1'b1) begin n_err++;
      $display("FAIL timeout_pulse rv=%0d err=%b want 1/1", g_rv_n, g_rerr); end
    n_vec++; if (g_rdata !== 32'h0) begin n_err++;
      $display("FAIL timeout_rdata got=%h want=00000000", g_rdata); end
    n_vec++; if (g_arv_cyc !== TMO || g_ar_hs !== 0) begin n_err++;
      $display("FAIL timeout_arvalid_cycles got=%0d want=%0d", g_arv_cyc, TMO); end
  endtask

  task automatic test_reset_mid();
    int seen_r = 0, pulses = 0, stray = 0;
    run_txn(1, 32'h8000_0008, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_0001, 2'b00, 2'b00);
    lsu_araddr = 32'h8000_000C; lsu_arvalid = 1; arready = 1;
    for (int i = 0; i < 20 && seen_r == 0; i++) begin
      @(posedge clk); #1;
      if (rready) seen_r = 1;
    end
    n_vec++; if (seen_r == 0) begin n_err++; $display("FAIL rstmid_reach_r got=0 want=1"); end
    rst = 1; lsu_arvalid = 0; arready = 0;
    @(posedge clk); #1;
    rst = 0; rvalid = 1; rdata = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (lsu_rvalid) pulses++;
      if (arvalid || rready || awvalid || wvalid || bready) stray++;
    end
    slave_idle();
    n_vec++; if (pulses !== 0 || stray !== 0) begin n_err++;
      $display("FAIL rstmid_late_resp pulses=%0d busy_cycles=%0d want 0/0", pulses, stray); end
    n_vec++; if (lsu_rdata !== 32'h0) begin n_err++;
      $display("FAIL rstmid_rdata got=%h want=00000000", lsu_rdata); end
    run_txn(1, 32'h8000_0010, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h7777_8888, 2'b00, 2'b00);
    check_load("load_after_reset", 32'h8000_0010, 32'h7777_8888, 2'b00);
  endtask

  initial begin
    rst = 1;
    lsu_araddr = 0; lsu_arvalid = 0; lsu_rstrb = 0;
    lsu_awaddr = 0; lsu_awvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0;
    slave_idle();
    test_reset();
    test_load();
    test_store();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
